// File: rtl/lighthouse_sensor_frame.sv
// Eight-channel lighthouse receiver: measures sync-flash-to-sweep-hit time per photodiode
// and publishes all eight results as one 256-bit frame word every FRAME_PERIOD cycles.
module lighthouse_sensor_frame #(
  parameter int unsigned FRAME_PERIOD   = 50000,
  parameter logic [31:0] GLITCH_MAX     = 32'd4,
  parameter logic [31:0] SYNC_MIN_WIDTH = 32'd3000,
  parameter logic [31:0] SYNC_MAX_WIDTH = 32'd7000,
  parameter logic [31:0] AXIS_THRESHOLD = 32'd5000,
  parameter logic [31:0] SWEEP_TIMEOUT  = 32'd400000,
  parameter logic [31:0] TS_INIT        = 32'd0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [7:0]   sensor,
  output logic [255:0] data,
  output logic         dataReady
);

  localparam int CW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, PULSE, ARMED, ARMED_PULSE} state_t;

  logic [7:0]    sync_a;
  logic [7:0]    sync_b;
  logic [7:0]    sync_q;
  logic [31:0]   ts;
  logic [CW-1:0] frame_count;
  logic          tick;
  logic [255:0]  words;

  assign tick = (frame_count == FRAME_LAST);

  // Synchronizers, free-running timestamp, frame counter and the frame snapshot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_a      <= '0;
      sync_b      <= '0;
      sync_q      <= '0;
      ts          <= TS_INIT;
      frame_count <= '0;
      data        <= '0;
      dataReady   <= 1'b0;
    end else begin
      sync_a      <= sensor;
      sync_b      <= sync_a;
      sync_q      <= sync_b;
      ts          <= ts + 32'd1;
      frame_count <= tick ? '0 : frame_count + CW'(1);
      dataReady   <= tick;
      if (tick) data <= words;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_sensor
    state_t      state;
    state_t      state_next;
    logic [31:0] rise_t;
    logic [31:0] sync_t;
    logic [31:0] width;
    logic [31:0] delta;
    logic [31:0] age;
    logic [28:0] delta_sat;
    logic [31:0] word;
    logic        axis;
    logic        rise;
    logic        fall;
    logic        load_rise;
    logic        load_sync;
    logic        write_word;

    assign rise      = sync_b[i] & ~sync_q[i];
    assign fall      = ~sync_b[i] & sync_q[i];
    assign width     = ts - rise_t;
    assign delta     = rise_t - sync_t;
    assign age       = ts - sync_t;
    assign delta_sat = (delta[31:29] != 3'b000) ? 29'h1FFF_FFFF : delta[28:0];
    assign words[32*i +: 32] = word;

    // A sweep landing on the tick cycle keeps its word for the next frame.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state  <= IDLE;
        rise_t <= '0;
        sync_t <= '0;
        axis   <= 1'b0;
        word   <= '0;
      end else begin
        state <= state_next;
        if (load_rise) rise_t <= ts;
        if (load_sync) begin
          sync_t <= rise_t;
          axis   <= (width >= AXIS_THRESHOLD);
        end
        if (write_word) word <= {1'b1, axis, 1'b0, delta_sat};
        else if (tick)  word <= '0;
      end
    end

    always_comb begin
      state_next = state;
      load_rise  = 1'b0;
      load_sync  = 1'b0;
      write_word = 1'b0;
      if ((state == ARMED || state == ARMED_PULSE) && age > SWEEP_TIMEOUT) begin
        state_next = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state_next = PULSE;
              load_rise  = 1'b1;
            end
          end
          ARMED: begin
            if (rise) begin
              state_next = ARMED_PULSE;
              load_rise  = 1'b1;
            end
          end
          PULSE, ARMED_PULSE: begin
            if (fall) begin
              if (width < GLITCH_MAX) begin
                state_next = (state == PULSE) ? IDLE : ARMED;
              end else if (width >= SYNC_MIN_WIDTH && width <= SYNC_MAX_WIDTH) begin
                state_next = ARMED;
                load_sync  = 1'b1;
              end else if (width > SYNC_MAX_WIDTH) begin
                state_next = IDLE;
              end else begin
                state_next = IDLE;
                write_word = (state == ARMED_PULSE);
              end
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lighthouse_sensor_frame.sv
// Bench for lighthouse_sensor_frame with shortened timing parameters and a timestamp
// that starts just below its wrap point, so every run crosses the 2^32 boundary.
module tb_lighthouse_sensor_frame;

  localparam int FP     = 1000;
  localparam int GLITCH = 4;
  localparam int SMIN   = 30;
  localparam int SMAX   = 70;
  localparam int AXIS   = 50;
  localparam int TOUT   = 2000;
  localparam logic [31:0] TS_START = 32'hFFFF_FC00;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   sensor = '0;
  logic [255:0] data;
  logic         dataReady;

  lighthouse_sensor_frame #(
    .FRAME_PERIOD(FP),
    .GLITCH_MAX(GLITCH),
    .SYNC_MIN_WIDTH(SMIN),
    .SYNC_MAX_WIDTH(SMAX),
    .AXIS_THRESHOLD(AXIS),
    .SWEEP_TIMEOUT(TOUT),
    .TS_INIT(TS_START)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .sensor(sensor),
    .data(data),
    .dataReady(dataReady)
  );

  always #5 clock = ~clock;

  typedef struct { int s; int rise; int fall; } pulse_t;
  typedef struct { int s; int edge_no; logic [31:0] word; } write_t;
  typedef struct {
    int s; int sync_w; int extra_off; int extra_w; int sweep_off; int sweep_w; logic [31:0] word;
  } vector_t;

  pulse_t  pulses[$];
  write_t  writes[$];
  vector_t vectors[15];
  int      checks = 0;
  int      failures = 0;
  string   tag = "";

  task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s %s: got %h, expected %h", tag, name, actual, expected);
    end
  endtask

  function automatic logic [31:0] sweep_word(bit ax, int d);
    logic [31:0] dv;
    dv = d;
    return {1'b1, ax, 1'b0, (dv >= 32'h2000_0000) ? 29'h1FFF_FFFF : dv[28:0]};
  endfunction

  // A frame snapshot holds the last word written in the frame period that ends at its tick.
  function automatic logic [31:0] frame_word(int s, int k);
    logic [31:0] w;
    w = '0;
    if (k >= 1)
      foreach (writes[j])
        if (writes[j].s == s && writes[j].edge_no >= (k - 1) * FP && writes[j].edge_no < k * FP)
          w = writes[j].word;
    return w;
  endfunction

  // Event-level model: one call per raw pulse, times in cycles since reset release.
  task automatic model_pulse(int s, int r, int f, inout bit armed, inout int sy, inout bit ax);
    bit pre;
    int w;
    pre = armed;
    w = f - r;
    if (armed) begin
      if (r - sy > TOUT + 1) pre = 1'b0;
      else if (r - sy == TOUT + 1 || f - sy > TOUT) begin
        armed = 1'b0;
        return;
      end
    end
    if (w < GLITCH) armed = pre;
    else if (w >= SMIN && w <= SMAX) begin
      armed = 1'b1;
      sy = r;
      ax = (w >= AXIS);
    end else if (w > SMAX) armed = 1'b0;
    else begin
      if (pre) writes.push_back('{s, f + 3, sweep_word(ax, r - sy)});
      armed = 1'b0;
    end
  endtask

  task automatic apply_reset();
    sensor = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    pulses.delete();
    writes.delete();
  endtask

  task automatic apply_stimulus(int ncyc);
    logic [7:0] wave [];
    int e;
    wave = new[ncyc];
    foreach (wave[c]) wave[c] = '0;
    foreach (pulses[j])
      for (int c = pulses[j].rise; c < pulses[j].fall && c < ncyc; c++) wave[c][pulses[j].s] = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      sensor = wave[c];
      @(posedge clock);
      #1;
      e = c + 1;
      if ((e % FP) inside {0, 1, FP / 2, FP - 1}) begin
        check_output($sformatf("dataReady@%0d", e), 32'(dataReady), (e % FP == 0) ? 32'd1 : 32'd0);
        for (int i = 0; i < 8; i++)
          check_output($sformatf("word%0d@%0d", i, e), data[32*i +: 32], frame_word(i, e / FP));
      end
    end
    sensor = '0;
  endtask

  task automatic gen_random(int nframes);
    int picks [8] = '{3, 4, 29, 30, 49, 50, 70, 71};
    for (int s = 0; s < 8; s++) begin
      bit armed;
      bit ax;
      int sy;
      int t;
      int gap;
      int cat;
      int w;
      armed = 1'b0;
      ax = 1'b0;
      sy = 0;
      t = 5;
      while (1) begin
        gap = $urandom_range(900, 3);
        cat = $urandom_range(9, 0);
        case (cat)
          0:          w = $urandom_range(GLITCH - 1, 1);
          1, 2, 3:    w = $urandom_range(SMAX, SMIN);
          4, 5, 6, 7: w = $urandom_range(SMIN - 1, GLITCH);
          8:          w = $urandom_range(150, SMAX + 1);
          default:    w = picks[$urandom_range(7, 0)];
        endcase
        if (t + gap + w >= nframes * FP - 10) break;
        pulses.push_back('{s, t + gap, t + gap + w});
        model_pulse(s, t + gap, t + gap + w, armed, sy, ax);
        t = t + gap + w;
      end
    end
  endtask

  initial begin
    // sensor, sync width, extra pulse offset/width (0 = none), sweep offset/width, expected word
    vectors[0]  = '{0, 35,   0,  0, 1000, 10, 32'h8000_03E8};
    vectors[1]  = '{5, 60,   0,  0, 1000, 10, 32'hC000_03E8};
    vectors[2]  = '{2, 35, 300,  2,  800, 10, 32'h8000_0320};
    vectors[3]  = '{3, 35, 300, 90,  800, 10, 32'h0000_0000};
    vectors[4]  = '{4, 35,   0,  0, 2001, 10, 32'h0000_0000};
    vectors[5]  = '{6, 35,   0,  0, 1990, 10, 32'h8000_07C6};
    vectors[6]  = '{6, 35,   0,  0, 1991, 10, 32'h0000_0000};
    vectors[7]  = '{1, 70,   0,  0,  500, 29, 32'hC000_01F4};
    vectors[8]  = '{7, 30,   0,  0,  400,  4, 32'h8000_0190};
    vectors[9]  = '{0, 71,   0,  0,  300, 10, 32'h0000_0000};
    vectors[10] = '{3, 49,   0,  0,  300, 10, 32'h8000_012C};
    vectors[11] = '{3, 50,   0,  0,  300, 10, 32'hC000_012C};
    vectors[12] = '{2, 35,   0,  0,  300,  3, 32'h0000_0000};
    vectors[13] = '{4, 35, 300, 60,  800, 10, 32'hC000_01F4};
    vectors[14] = '{5, 29,   0,  0,  300, 10, 32'h0000_0000};

    tag = "idle";
    apply_reset();
    check_output("reset_data", data[31:0], 32'h0);
    check_output("reset_ready", 32'(dataReady), 32'h0);
    apply_stimulus(2 * FP + 2);

    for (int v = 0; v < 15; v++) begin
      int last;
      tag = $sformatf("vec%0d", v);
      apply_reset();
      pulses.push_back('{vectors[v].s, 10, 10 + vectors[v].sync_w});
      if (vectors[v].extra_w > 0)
        pulses.push_back('{vectors[v].s, 10 + vectors[v].extra_off,
                           10 + vectors[v].extra_off + vectors[v].extra_w});
      pulses.push_back('{vectors[v].s, 10 + vectors[v].sweep_off,
                         10 + vectors[v].sweep_off + vectors[v].sweep_w});
      last = 10 + vectors[v].sweep_off + vectors[v].sweep_w + 3;
      if (vectors[v].word != 32'h0) writes.push_back('{vectors[v].s, last, vectors[v].word});
      apply_stimulus((last / FP + 2) * FP);
    end

    // Sweep words landing on the tick edge and one cycle before it.
    tag = "tick";
    apply_reset();
    pulses.push_back('{1, 10, 45});
    pulses.push_back('{1, 1987, 1997});
    pulses.push_back('{2, 10, 45});
    pulses.push_back('{2, 1986, 1996});
    writes.push_back('{1, 2000, 32'h8000_07B9});
    writes.push_back('{2, 1999, 32'h8000_07B8});
    apply_stimulus(4 * FP);

    // Reset mid-frame while a pulse is in flight and a sync is armed.
    tag = "midreset";
    apply_reset();
    pulses.push_back('{0, 10, 45});
    pulses.push_back('{0, 310, 320});
    pulses.push_back('{3, 1200, 1240});
    pulses.push_back('{3, 1495, 1600});
    writes.push_back('{0, 323, 32'h8000_012C});
    apply_stimulus(1500);
    #2 reset_n = 1'b0;
    #1;
    check_output("async_data", data[31:0], 32'h0);
    check_output("async_ready", 32'(dataReady), 32'h0);
    apply_reset();
    apply_stimulus(2 * FP + 2);

    tag = "random";
    apply_reset();
    gen_random(10);
    apply_stimulus(10 * FP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
